// File: rtl/pps_pkg.sv
// -----------------------------------------------------------------------------
// pps_pkg
// Shared definitions for the PPS timekeeper:
//   - tracking state encoding (also the status readback state field)
//   - readback select codes for the 32-bit dat_o register port
//   - status word field positions and a helper that packs the status word
// -----------------------------------------------------------------------------
package pps_pkg;

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'b00,
      LOCKED     = 2'b01,
      LOST       = 2'b10
   } pps_state_t;

   localparam logic [1:0] SEL_SEC    = 2'd0;
   localparam logic [1:0] SEL_PERIOD = 2'd1;
   localparam logic [1:0] SEL_STATUS = 2'd2;
   localparam logic [1:0] SEL_CYC    = 2'd3;

   localparam int STAT_GLITCH_LSB = 0;
   localparam int STAT_GLITCH_W   = 16;
   localparam int STAT_STATE_LSB  = 16;
   localparam int STAT_STATE_W    = 2;

   // Status word: {14'b0, state[1:0], glitch_cnt[15:0]}
   function automatic logic [31:0] pack_status(input pps_state_t st,
                                               input logic [STAT_GLITCH_W-1:0] glitch);
      logic [31:0] s;
      s = '0;
      s[STAT_STATE_LSB  +: STAT_STATE_W]  = st;
      s[STAT_GLITCH_LSB +: STAT_GLITCH_W] = glitch;
      return s;
   endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// -----------------------------------------------------------------------------
// pps_edge_sync
// Two-flop synchronizer for an asynchronous pulse input followed by a delay
// flop; rise_o is a one-cycle pulse on each synchronized rising edge.
// Ports:
//   clk_i    system clock
//   rst_n_i  synchronous active-low reset (clears all three flops)
//   async_i  asynchronous input level
//   rise_o   combinational rising-edge strobe (sync2 & ~dly)
// -----------------------------------------------------------------------------
module pps_edge_sync
   import pps_pkg::*;
(
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic async_i,
   output logic rise_o
);

   logic sync1;
   logic sync2;
   logic dly;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         dly   <= 1'b0;
      end else begin
         sync1 <= async_i;
         sync2 <= sync1;
         dly   <= sync2;
      end
   end

   assign rise_o = sync2 & ~dly;

endmodule

// File: rtl/pps_timekeeper.sv
// -----------------------------------------------------------------------------
// pps_timekeeper
// Consumes the selected (asynchronous) PPS: synchronizes it, rejects edges
// that arrive too soon after the last accepted one, emits one-cycle second
// ticks, keeps a software-writable seconds counter, measures the period
// between accepted edges and flags loss of PPS.
//
// Optional feature: define PPS_HOLDOVER_EN to build the holdover counter,
// which keeps ticking once per NOMINAL cycles while PPS is lost.
//
// Parameters:
//   NOMINAL     nominal clock cycles per second
//   MIN_PERIOD  edges sooner than this after the last accepted edge are glitches
//   TIMEOUT     cycles without an edge before declaring loss
// Ports:
//   clk_i       system clock (sole domain)
//   rst_n_i     synchronous active-low reset
//   pps_i       selected PPS, asynchronous
//   wr_i/dat_i  load seconds counter (write beats a same-cycle increment)
//   sel_i       readback select: 0 sec, 1 period, 2 status, 3 live cyc_cnt
//   dat_o       combinational readback
//   pps_tick_o  one-cycle second tick (real or holdover)
//   lost_o      high while in LOST
//   sec_o       seconds counter
// -----------------------------------------------------------------------------
module pps_timekeeper
   import pps_pkg::*;
#(
   parameter int unsigned NOMINAL    = 33000000,
   parameter int unsigned MIN_PERIOD = 32000000,
   parameter int unsigned TIMEOUT    = 34000000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        pps_i,
   input  logic        wr_i,
   input  logic [31:0] dat_i,
   input  logic [1:0]  sel_i,
   output logic [31:0] dat_o,
   output logic        pps_tick_o,
   output logic        lost_o,
   output logic [31:0] sec_o
);

   if (!(MIN_PERIOD < NOMINAL && NOMINAL < TIMEOUT && TIMEOUT < 2*NOMINAL)) begin : g_bad_cfg
      $error("pps_timekeeper: parameters must satisfy MIN_PERIOD < NOMINAL < TIMEOUT < 2*NOMINAL");
   end

   localparam logic [31:0] MIN_M1 = 32'(MIN_PERIOD - 1);
   localparam logic [31:0] TO_M1  = 32'(TIMEOUT - 1);

   pps_state_t  state;
   logic [31:0] cyc_cnt;
   logic [31:0] period;
   logic [15:0] glitch_cnt;
   logic [31:0] sec;
   logic        tick;
   logic        lost;

   logic        rise;
   logic        accept;   // edge taken as a real second
   logic        glitch;   // edge rejected as too early
   logic        timeout;  // LOCKED with no edge for TIMEOUT cycles
   logic        synth;    // holdover tick
   logic        advance;  // any tick this cycle

   pps_edge_sync u_sync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .async_i (pps_i),
      .rise_o  (rise)
   );

`ifdef PPS_HOLDOVER_EN
   // hold_cnt is preloaded with TIMEOUT-NOMINAL at loss so that its wrap to
   // zero lines up with whole seconds after the last real edge.
   localparam logic [31:0] NOM_M1    = 32'(NOMINAL - 1);
   localparam logic [31:0] HOLD_INIT = 32'(TIMEOUT - NOMINAL);

   logic [31:0] hold_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         hold_cnt <= '0;
      end else if (timeout) begin
         hold_cnt <= HOLD_INIT;
      end else if (state == LOST) begin
         hold_cnt <= synth ? 32'd0 : hold_cnt + 32'd1;
      end
   end

   // A real edge in LOST takes priority over a coincident holdover tick.
   assign synth = !rise && (state == LOST) && (hold_cnt == NOM_M1);
`else
   assign synth = 1'b0;
`endif

   // WAIT_FIRST and LOST take any edge; LOCKED applies the glitch window.
   // The edge beats the timeout when both land on the same cycle.
   always_comb begin
      accept  = 1'b0;
      glitch  = 1'b0;
      timeout = 1'b0;
      if (rise) begin
         if (state == LOCKED && cyc_cnt < MIN_M1) glitch = 1'b1;
         else                                     accept = 1'b1;
      end else if (state == LOCKED && cyc_cnt == TO_M1) begin
         timeout = 1'b1;
      end
   end

   assign advance = accept | synth;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state      <= WAIT_FIRST;
         cyc_cnt    <= '0;
         period     <= '0;
         glitch_cnt <= '0;
         sec        <= '0;
         tick       <= 1'b0;
         lost       <= 1'b0;
      end else begin
         tick <= advance;

         if (advance)                 cyc_cnt <= '0;
         else if (cyc_cnt != '1)      cyc_cnt <= cyc_cnt + 32'd1;

         // Software write wins over the tick increment; the tick still fires.
         if (wr_i)                    sec <= dat_i;
         else if (advance)            sec <= sec + 32'd1;

         if (glitch && glitch_cnt != '1) glitch_cnt <= glitch_cnt + 16'd1;

         // Period is only meaningful between two edges seen while locked.
         if (accept && state == LOCKED) period <= cyc_cnt + 32'd1;

         case (state)
            WAIT_FIRST: begin
               if (accept) state <= LOCKED;
            end
            LOCKED: begin
               if (timeout) begin
                  state <= LOST;
                  lost  <= 1'b1;
               end
            end
            LOST: begin
               if (accept) begin
                  state <= LOCKED;
                  lost  <= 1'b0;
               end
            end
            default: begin
               state <= WAIT_FIRST;
               lost  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      dat_o = '0;
      case (sel_i)
         SEL_SEC:    dat_o = sec;
         SEL_PERIOD: dat_o = period;
         SEL_STATUS: dat_o = pack_status(state, glitch_cnt);
         SEL_CYC:    dat_o = cyc_cnt;
         default:    dat_o = '0;
      endcase
   end

   assign pps_tick_o = tick;
   assign lost_o     = lost;
   assign sec_o      = sec;

endmodule

// File: tb/tb_pps_timekeeper.sv
// -----------------------------------------------------------------------------
// tb_pps_timekeeper
// Scoreboard bench. The stimulus process plans each PPS pulse by the interval
// (in cycles) between the previous tick and the tick it should produce, works
// out the resulting events from the timing rules (tick times, loss time,
// holdover ticks, register values) and queues them with their cycle stamps.
// The monitor pops events as their cycle arrives and compares the DUT; any
// tick or loss it was not told about is reported as well.
// Honors PPS_HOLDOVER_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_pps_timekeeper;

   localparam int N    = 100;
   localparam int MINP = 90;
   localparam int TO   = 150;

   typedef enum int {EV_TICK, EV_LOSS, EV_SNAP} ev_kind_t;
   typedef struct {
      int          t;
      ev_kind_t    kind;
      logic [31:0] sec;
      logic [31:0] period;
      logic [31:0] status;
      logic [31:0] cyc;
      logic        lost;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pps;
   logic        wr;
   logic [31:0] dat_in;
   logic [1:0]  sel;
   logic [31:0] dat_out;
   logic        tick;
   logic        lost;
   logic [31:0] sec;

   pps_timekeeper #(.NOMINAL(N), .MIN_PERIOD(MINP), .TIMEOUT(TO)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .pps_i      (pps),
      .wr_i       (wr),
      .dat_i      (dat_in),
      .sel_i      (sel),
      .dat_o      (dat_out),
      .pps_tick_o (tick),
      .lost_o     (lost),
      .sec_o      (sec)
   );

   always #5 clk = ~clk;

   int now = 0;
   always @(posedge clk) now <= now + 1;

   int checks   = 0;
   int failures = 0;
   ev_t q[$];

   // Reference model state: last tick cycle and the register values behind it
   int          m_state;  // 0 wait-first, 1 locked, 2 lost
   int          m_T;
   logic [31:0] m_sec;
   logic [31:0] m_period;
   logic [15:0] m_glitch;
   logic        m_lost;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, now, act, exp);
      end
   endtask

   task automatic push(input int t, input ev_kind_t k, input int cycv);
      ev_t e;
      e.t      = t;
      e.kind   = k;
      e.sec    = m_sec;
      e.period = m_period;
      e.status = (32'(m_state) << 16) | {16'h0, m_glitch};
      e.cyc    = 32'(cycv);
      e.lost   = m_lost;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (now < t) step();
   endtask

   task automatic snap(input int k);
      int t;
      t = m_T + k;
      if (t <= now) t = now + 1;
      push(t, EV_SNAP, t - m_T);
   endtask

   task automatic model_reset(input int t);
      m_state  = 0;
      m_T      = t;
      m_sec    = '0;
      m_period = '0;
      m_glitch = '0;
      m_lost   = 1'b0;
   endtask

   // d: cycles from the previous tick to the tick this edge would produce
   // (from "now" when waiting for the first edge). wmode: 0 no write,
   // 1 write landing with the tick, 2 write one cycle after pps rises.
   task automatic pulse(input int d_in, input int wmode, input logic [31:0] wdat, input int hold);
      int n, tt, base, d;
      bit clash;
      d = d_in;
`ifdef PPS_HOLDOVER_EN
      // keep the real edge clear of holdover tick instants
      if (m_state == 1 && d > TO) begin
         do begin
            clash = 1'b0;
            for (int m = 2; m * N <= d + 6; m++)
               if (d >= m * N - 5 && d <= m * N + 5) clash = 1'b1;
            if (clash) d += 11;
         end while (clash);
      end
`else
      clash = 1'b0;
`endif
      n  = (m_state == 0) ? now + d : m_T + d - 3;
      tt = n + 3;

      if (m_state == 1 && d < MINP) begin
         m_glitch = m_glitch + 16'd1;
         if (wmode != 0) m_sec = wdat;
      end else begin
         if (m_state == 1 && d > TO) begin
            base    = m_T;
            m_state = 2;
            m_lost  = 1'b1;
            push(base + TO, EV_LOSS, TO);
            push(base + TO + 10, EV_SNAP, TO + 10);
`ifdef PPS_HOLDOVER_EN
            for (int m = 2; base + m * N < tt; m++) begin
               m_sec = m_sec + 32'd1;
               m_T   = base + m * N;
               push(m_T, EV_TICK, 0);
            end
`endif
         end
         if (wmode == 2) m_sec = wdat;
         if (wmode == 1) m_sec = wdat;
         else            m_sec = m_sec + 32'd1;
         if (m_state == 1) m_period = 32'(d);
         m_state = 1;
         m_lost  = 1'b0;
         m_T     = tt;
         push(tt, EV_TICK, 0);
      end

      wait_until(n);
      pps = 1'b1;
      if (wmode == 2) begin wr = 1'b1; dat_in = wdat; end
      step();
      wr = 1'b0;
      step();
      if (wmode == 1) begin wr = 1'b1; dat_in = wdat; end
      step();
      wr = 1'b0;
      wait_until(n + hold);
      pps = 1'b0;
   endtask

   task automatic do_reset(input int at);
      model_reset(at + 1);
      push(at + 1, EV_SNAP, 0);
      push(at + 6, EV_SNAP, 5);
      wait_until(at);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   // Monitor: the only driver of sel
   initial begin
      ev_t  e;
      logic prev_lost;
      logic cur_tick, cur_lost;
      bit   tick_seen, loss_seen;
      sel       = 2'd0;
      prev_lost = 1'b0;
      forever begin
         @(negedge clk);
         cur_tick  = tick;
         cur_lost  = lost;
         tick_seen = 1'b0;
         loss_seen = 1'b0;
         while (q.size() > 0 && q[0].t <= now) begin
            e = q.pop_front();
            if (e.t < now) begin
               chk("event_missed", 32'(now), 32'(e.t));
            end else if (e.kind == EV_LOSS) begin
               loss_seen = 1'b1;
               chk("loss_lost_o", {31'b0, cur_lost}, 32'd1);
               sel = 2'd2; #1;
               chk("loss_status", dat_out, e.status);
            end else begin
               if (e.kind == EV_TICK) begin
                  tick_seen = 1'b1;
                  chk("tick_present", {31'b0, cur_tick}, 32'd1);
               end else begin
                  chk("snap_no_tick", {31'b0, cur_tick}, 32'd0);
               end
               chk("sec_o", sec, e.sec);
               chk("lost_o", {31'b0, cur_lost}, {31'b0, e.lost});
               sel = 2'd0; #1; chk("rd_sec", dat_out, e.sec);
               sel = 2'd1; #1; chk("rd_period", dat_out, e.period);
               sel = 2'd2; #1; chk("rd_status", dat_out, e.status);
               sel = 2'd3; #1; chk("rd_cyc", dat_out, e.cyc);
            end
         end
         if (!tick_seen && cur_tick) chk("spurious_tick", {31'b0, cur_tick}, 32'd0);
         if (!loss_seen && cur_lost && !prev_lost) chk("spurious_loss", {31'b0, cur_lost}, 32'd0);
         prev_lost = cur_lost;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", now);
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      rst_n  = 1'b0;
      pps    = 1'b0;
      wr     = 1'b0;
      dat_in = '0;
      model_reset(4);
      push(4, EV_SNAP, 0);
      push(9, EV_SNAP, 5);
      wait_until(4);
      rst_n = 1'b1;

      // first edge: tick, sec=1, period stays 0
      pulse(10, 0, 32'h0, 4);
      snap(5);
      // regular seconds, one of them with pps held high
      pulse(100, 0, 32'h0, 4);
      pulse(100, 0, 32'h0, 60);
      pulse(100, 0, 32'h0, 4);
      snap(7);
      // glitch at 50, then accepted at 100
      pulse(50, 0, 32'h0, 4);
      pulse(100, 0, 32'h0, 4);
      snap(4);
      // glitch-window and timeout boundaries
      pulse(89, 0, 32'h0, 4);
      pulse(100, 0, 32'h0, 4);
      pulse(90, 0, 32'h0, 4);
      pulse(150, 0, 32'h0, 4);
      snap(6);
      // loss, holdover (if built), recovery
      pulse(350, 0, 32'h0, 4);
      snap(8);
      // write coincident with tick, then wrap through 0xFFFFFFFF
      pulse(100, 1, 32'h12345678, 4);
      pulse(100, 2, 32'hFFFFFFFF, 4);
      snap(5);
      // one-cycle reset mid-LOCKED; next edge is a first edge again
      do_reset(m_T + 30);
      pulse(10, 0, 32'h0, 4);
      snap(5);
      pulse(100, 0, 32'h0, 4);

      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, 9);
         if (r < 3)
            pulse($urandom_range(20, 80), ($urandom_range(0, 3) == 0) ? 2 : 0, $urandom, 4);
         if (r == 9)
            pulse($urandom_range(TO + 15, 420), $urandom_range(0, 1), $urandom, 4);
         else
            pulse($urandom_range(MINP, TO), $urandom_range(0, 2), $urandom, $urandom_range(4, 15));
         snap($urandom_range(3, 15));
      end

      for (int i = 0; i < 3000 && q.size() > 0; i++) step();
      step();
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pps_timekeeper.md
# pps_timekeeper

Downstream consumer of the selected PPS (the PPS mux output) for the TURFIO housekeeping path. Synchronizes the asynchronous PPS, rejects glitches, and emits one-cycle second ticks. Maintains a software-settable seconds counter, measures the clock-cycle period between edges, and flags loss of PPS. Readback goes through the same 32-bit wr/dat register port style used by the PPS control module.

## Interface
Parameters:
- NOMINAL, 33000000, nominal clock cycles per second.
- MIN_PERIOD, 32000000, edges arriving earlier than this (cycles since last accepted edge) are glitches.
- TIMEOUT, 34000000, cycles without an edge before declaring loss. Requires MIN_PERIOD < NOMINAL < TIMEOUT < 2*NOMINAL.

Ports:
- clk_i  in  1  system clock; sole clock domain.
- rst_n_i  in  1  reset, synchronous, active-low.
- pps_i  in  1  selected PPS, asynchronous to clk_i.
- wr_i  in  1  write strobe; loads the seconds counter from dat_i.
- dat_i  in  32  write data.
- sel_i  in  2  readback select.
- dat_o  out  32  readback: 0 = sec, 1 = period, 2 = status {14'b0, state[1:0], glitch_cnt[15:0]}, 3 = live cyc_cnt. Combinational from registers.
- pps_tick_o  out  1  one-cycle second tick, from a real edge or a holdover edge.
- lost_o  out  1  high in state LOST.
- sec_o  out  32  seconds counter.

## Operation
- Input: 2-FF synchronizer on pps_i, then a delay FF. A rising edge is (sync2 & ~dly).
- cyc_cnt (32b): increments every cycle and saturates at 0xFFFFFFFF. Cleared on every accepted edge or holdover tick.
- States: WAIT_FIRST (00), LOCKED (01), LOST (10).
  - WAIT_FIRST:
    - Any edge is accepted: go to LOCKED, tick, sec+1, clear cyc_cnt. period is not updated.
    - No timeout is applied in this state.
  - LOCKED, on an edge:
    - If cyc_cnt < MIN_PERIOD-1: ignore the edge. glitch_cnt+1 (16b, saturating). No other effect.
    - Otherwise: accept it. period <= cyc_cnt+1, tick, sec+1, clear cyc_cnt.
  - LOCKED, with no edge and cyc_cnt == TIMEOUT-1: go to LOST. hold_cnt <= TIMEOUT-NOMINAL. No tick.
  - LOST:
    - Any edge is accepted: go to LOCKED, tick, sec+1, clear cyc_cnt. period is not updated.
    - Holdover behaviour is set under Configuration.
- wr_i: sec <= dat_i. If an increment happens in the same cycle, the write wins and the increment is dropped. The tick still fires.
- Arithmetic: all counters are unsigned. sec wraps 0xFFFFFFFF -> 0.
- Reset mid-operation returns everything to reset values immediately. Any in-flight synchronizer state is discarded.

## Timing
- Reset values:
  - state=WAIT_FIRST, pps_tick_o=0, lost_o=0, sec_o=0.
  - period=0, glitch_cnt=0, cyc_cnt=0, hold_cnt=0.
  - Synchronizer FFs = 0.
- Latency: pps_tick_o asserts on the 3rd rising clk_i after pps_i rises (2 sync + 1 registered output).
- In the same cycle as the tick:
  - sec_o, period and the cleared cyc_cnt update.
  - lost_o deasserts, or asserts on the cycle following cyc_cnt == TIMEOUT-1.
- pps_tick_o is exactly one cycle wide. A held-high pps_i produces no further ticks.
- dat_o reflects register state in the same cycle sel_i changes.

## Configuration
- PPS_HOLDOVER_EN defined:
  - In LOST, hold_cnt increments every cycle.
  - When hold_cnt == NOMINAL-1: emit a synthetic tick, sec+1, hold_cnt <= 0, cyc_cnt <= 0. The state stays LOST.
  - Synthetic ticks therefore land at 2*NOMINAL, 3*NOMINAL, ... cycles after the last real edge.
- PPS_HOLDOVER_EN undefined:
  - hold_cnt is not built. LOST emits no ticks and sec is frozen.
  - The status state field still reads 10.

## Structure
- Shared package (pps_pkg):
  - State enum: WAIT_FIRST/LOCKED/LOST.
  - Readback select constants: SEL_SEC, SEL_PERIOD, SEL_STATUS, SEL_CYC.
  - Status field bit positions.
- One sub-module, pps_edge_sync: the 2-FF synchronizer plus rising-edge detector, with the reset port rst_n_i. Reusable for the PPS_G12 burst path.

## Test plan
Bench parameters: NOMINAL=100, MIN_PERIOD=90, TIMEOUT=150.
- Reset release, first pps_i rise -> tick 3 cycles later, sec_o=1, period=0, state LOCKED.
- Edges every 100 cycles x3 -> three ticks, sec_o=4, period readback (sel_i=1) = 100.
- Edge 50 cycles after an accepted edge -> no tick, glitch_cnt=1, sec unchanged. The next edge at 100 cycles is accepted with period=100.
- Stop edges with PPS_HOLDOVER_EN defined:
  - lost_o rises 150 cycles after the last tick.
  - Synthetic ticks at 200 and 300 cycles, sec +2.
  - A real edge then returns to LOCKED with lost_o=0 and period unchanged.
- Same stimulus with PPS_HOLDOVER_EN undefined -> lost_o=1, no ticks, sec frozen.
- wr_i with dat_i=0x12345678 in the same cycle as a tick -> sec_o=0x12345678 and the tick still asserted. Then sec=0xFFFFFFFF plus a tick -> sec_o=0.
- rst_n_i low for 1 cycle mid-LOCKED -> all readbacks 0, state WAIT_FIRST, next edge treated as first.
